// File: rtl/lap_stopwatch.sv
// Lap stopwatch: prescaled BCD counter with start/stop/clear control and a sticky full-scale overflow flag.
// Optional lap freeze of the display is built when LAP_STOPWATCH_LAP_EN is defined.
module lap_stopwatch #(
  parameter int unsigned TICK_DIV   = 1000000,
  parameter int unsigned TICK_W     = 20,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TOP_MOD    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    clear,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    overflow,
  output logic                    lap_hold
);
  localparam int unsigned       DW        = 4 * NUM_DIGITS;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [3:0]        TOP_LAST  = 4'(TOP_MOD - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e            state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic              run_q, run_d;
  logic              hold_q, hold_d;
  logic              tick, do_clear, carry;
  logic [3:0]        dig, dig_last;

  // Control FSM, prescaler and ripple-carry BCD counter.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    dig      = '0;
    dig_last = '0;
    tick     = (state_q == RUN) && (presc_q == TICK_LAST);
    do_clear = clear && (state_q != RUN);
    carry    = tick;

    if (do_clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end

    if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + TICK_W'(1);
    end

    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dig      = cnt_q[4*i +: 4];
      dig_last = (i == NUM_DIGITS - 1) ? TOP_LAST : 4'd9;
      if (carry) begin
        if (dig == dig_last) begin
          cnt_d[4*i +: 4] = 4'd0;
        end else begin
          cnt_d[4*i +: 4] = dig + 4'd1;
          carry           = 1'b0;
        end
      end
    end
    // Carry out of the top digit means every digit wrapped.
    if (carry) ovf_d = 1'b1;

    if (do_clear) begin
      presc_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end

    run_d = (state_d == RUN);
  end

`ifdef LAP_STOPWATCH_LAP_EN
  logic [DW-1:0] lap_q, lap_d;

  // Lap toggles the frozen display; capture takes the post-edge count.
  always_comb begin
    lap_d  = lap_q;
    hold_d = hold_q;
    if (do_clear) begin
      hold_d = 1'b0;
    end else if (lap && hold_q) begin
      hold_d = 1'b0;
    end else if (lap && (state_q == RUN)) begin
      lap_d  = cnt_d;
      hold_d = 1'b1;
    end
    disp_d = hold_d ? lap_d : cnt_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lap_q <= '0;
    else       lap_q <= lap_d;
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign hold_d     = 1'b0;
  assign disp_d     = cnt_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      run_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
    end
  end

  assign digits   = disp_q;
  assign running  = run_q;
  assign overflow = ovf_q;
  assign lap_hold = hold_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Scoreboard bench for lap_stopwatch (TICK_DIV=4, 4 digits, top mod 6); directed vectors with
// hand-computed expectations, checked by a decoupled monitor.
module tb_lap_stopwatch;
`ifdef LAP_STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] d;
    logic        r;
    logic        o;
    logic        h;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic [15:0] digits;
  logic        running, overflow, lap_hold;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  lap_stopwatch #(
    .TICK_DIV  (4),
    .TICK_W    (20),
    .NUM_DIGITS(4),
    .TOP_MOD   (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .digits    (digits),
    .running   (running),
    .overflow  (overflow),
    .lap_hold  (lap_hold)
  );

  always #5 clk = ~clk;

  task automatic exp_chk(input string nm, input logic [15:0] d, input logic r, input logic o,
                         input logic h);
    exp_t e;
    e.d = d; e.r = r; e.o = o; e.h = h;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic pulse(input logic ss, input logic cl, input logic lp);
    start_stop = ss; clear = cl; lap = lp;
    @(negedge clk);
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset is raised between clock edges so the check sees only the asynchronous path.
  task automatic async_reset(input string nm);
    #2 reset = 1'b1;
    #1 exp_chk(nm, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: pops each expectation and compares it with the outputs presented now.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      wait (exp_q.size() != 0);
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (digits !== e.d || running !== e.r || overflow !== e.o || lap_hold !== e.h) begin
        n_fail++;
        $display("FAIL %s: got digits=%h running=%b overflow=%b lap_hold=%b, expected digits=%h running=%b overflow=%b lap_hold=%b",
                 nm, digits, running, overflow, lap_hold, e.d, e.r, e.o, e.h);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    exp_chk("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cycles(2);
    exp_chk("idle_after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Start, pause, resume from held prescaler phase.
    pulse(1'b1, 1'b0, 1'b0);
    exp_chk("run_start", 16'h0000, 1'b1, 1'b0, 1'b0);
    cycles(40);
    exp_chk("run_40", 16'h0010, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    exp_chk("pause_enter", 16'h0010, 1'b0, 1'b0, 1'b0);
    cycles(20);
    exp_chk("pause_hold", 16'h0010, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    cycles(2);
    exp_chk("resume_phase_pre", 16'h0010, 1'b1, 1'b0, 1'b0);
    cycles(1);
    exp_chk("resume_phase_tick", 16'h0011, 1'b1, 1'b0, 1'b0);
    cycles(448);
    exp_chk("run_0123", 16'h0123, 1'b1, 1'b0, 1'b0);
    async_reset("async_reset_run");
    cycles(10);
    exp_chk("stopped_after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Pause at 7, then start_stop with clear.
    pulse(1'b1, 1'b0, 1'b0);
    cycles(28);
    exp_chk("run_0007", 16'h0007, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    exp_chk("pause_0007", 16'h0007, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    exp_chk("ss_clear_pause", 16'h0000, 1'b0, 1'b0, 1'b0);
    cycles(8);
    exp_chk("idle_no_count", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Carry chain, full-scale wrap and overflow handling.
    pulse(1'b1, 1'b0, 1'b0);
    cycles(2396);
    exp_chk("run_0599", 16'h0599, 1'b1, 1'b0, 1'b0);
    cycles(4);
    exp_chk("carry_0600", 16'h0600, 1'b1, 1'b0, 1'b0);
    cycles(21596);
    exp_chk("run_5999", 16'h5999, 1'b1, 1'b0, 1'b0);
    cycles(4);
    exp_chk("full_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    exp_chk("clear_in_run", 16'h0000, 1'b1, 1'b1, 1'b0);
    cycles(3);
    exp_chk("count_after_wrap", 16'h0001, 1'b1, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    exp_chk("pause_after_wrap", 16'h0001, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    exp_chk("clear_in_pause", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Lap freeze and release (or lap ignored when not built).
    pulse(1'b1, 1'b0, 1'b0);
    cycles(48);
    exp_chk("run_0012", 16'h0012, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    exp_chk("lap_capture", 16'h0012, 1'b1, 1'b0, LAP_EN);
    cycles(40);
    exp_chk("lap_frozen", LAP_EN ? 16'h0012 : 16'h0022, 1'b1, 1'b0, LAP_EN);
    pulse(1'b0, 1'b0, 1'b1);
    exp_chk("lap_release", 16'h0022, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    exp_chk("lap_recapture", 16'h0022, 1'b1, 1'b0, LAP_EN);
    async_reset("async_reset_hold");
    cycles(10);
    exp_chk("stopped_after_hold_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
